alu_result_demux: RTL and testbench

Write-back demultiplexer for the MCU datapath, the inverse of the ALU result selector. It takes one ALU result per cycle with a 2-bit destination code and steers it into one of four one-deep holding slots. Each slot presents its data to a downstream consumer until that consumer acknowledges it. The block applies backpressure to the ALU when the addressed slot is occupied, and counts stall cycles for performance debug.

---
 rtl/alu_result_demux.sv | 75 +++++++
 tb/tb_alu_result_demux.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_demux.sv
// alu_result_demux: write-back demultiplexer that steers one ALU result per
// cycle into one of four one-deep holding slots. Each slot holds its data
// until the downstream consumer acks it. The ALU sees backpressure while the
// addressed slot is occupied and not being released, and a saturating
// counter records how many cycles the ALU was stalled.
module alu_result_demux #(
   parameter int WIDTH   = 32,
   parameter int STALL_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [1:0]           in_sel,
   output logic [4*WIDTH-1:0]   out_data,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ack,
   output logic [STALL_W-1:0]   stall_cnt
);

   // Combinational control signals
   logic [3:0] rel_s;       // slots released this cycle (ack while full)
   logic       acc_s;       // result accepted this cycle
   logic [3:0] load_s;      // one-hot slot loaded this cycle
   logic       stall_s;     // ALU offers a result that is refused
   logic       stall_max_s; // counter is at its ceiling

   // Release, ready, accept and stall decode; the addressed slot may be
   // refilled in the same cycle it is released (pass-through ready).
   always_comb begin
      rel_s       = out_valid & out_ack;
      in_ready    = ~out_valid[in_sel] | out_ack[in_sel];
      acc_s       = in_valid & in_ready;
      stall_s     = in_valid & ~in_ready;
      stall_max_s = &stall_cnt;
      if (acc_s) begin
         load_s = 4'b0001 << in_sel;
      end else begin
         load_s = 4'b0000;
      end
   end

   // Slot data and occupancy: a load wins over a release of the same slot;
   // a release only clears the flag and leaves the data in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 4'b0000;
         out_data  <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load_s[k]) begin
               out_data[k*WIDTH +: WIDTH] <= in_data;
               out_valid[k]               <= 1'b1;
            end else if (rel_s[k]) begin
               out_valid[k]               <= 1'b0;
            end else begin
               out_valid[k]               <= out_valid[k];
            end
         end
      end
   end

   // Saturating stall counter; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_s && !stall_max_s) begin
         stall_cnt <= stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

endmodule

// File: tb/tb_alu_result_demux.sv
// Self-checking bench for alu_result_demux: an abstract slot model tracks the
// expected outputs and is compared every cycle; directed vectors add literal
// expectations at the interesting points.
module tb_alu_result_demux;

   localparam int WIDTH   = 32;
   localparam int STALL_W = 16;
   localparam int SAT     = 65535;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [1:0]           in_sel;
   logic [4*WIDTH-1:0]   out_data;
   logic [3:0]           out_valid;
   logic [3:0]           out_ack;
   logic [STALL_W-1:0]   stall_cnt;

   int errors = 0;
   int checks = 0;

   alu_result_demux #(.WIDTH(WIDTH), .STALL_W(STALL_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [WIDTH-1:0] m_data [4];
   bit               m_full [4];
   int               m_stall;

   function automatic bit m_ready();
      return !m_full[in_sel] || out_ack[in_sel];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            m_data[k] <= '0;
            m_full[k] <= 1'b0;
         end
         m_stall <= 0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (in_valid && m_ready() && int'(in_sel) == k) begin
               m_data[k] <= in_data;
               m_full[k] <= 1'b1;
            end else if (out_ack[k]) begin
               m_full[k] <= 1'b0;
            end
         end
         if (in_valid && !m_ready()) m_stall <= (m_stall >= SAT) ? SAT : m_stall + 1;
      end
   end

   // Per-cycle compare against the model, away from the rising edge.
   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 4; k++) begin
            chk("model_valid", 128'(out_valid[k]), 128'(m_full[k]));
            chk("model_data", 128'(out_data[k*WIDTH +: WIDTH]), 128'(m_data[k]));
         end
         chk("model_stall", 128'(stall_cnt), 128'(m_stall));
         chk("model_ready", 128'(in_ready), 128'(m_ready()));
      end
   end

   // Apply one cycle of stimulus and wait until just after the edge.
   task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] a);
      in_valid = v; in_sel = s; in_data = d; out_ack = a;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 32'h0, 4'b0000);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 32'h0; out_ack = 4'b0000;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("reset_valid", 128'(out_valid), 128'(4'b0000));
      chk("reset_data", 128'(out_data), 128'h0);
      chk("reset_stall", 128'(stall_cnt), 128'(16'h0));
      chk("reset_ready", 128'(in_ready), 128'(1'b1));

      // Single write to slot 2
      step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
      chk("w2_valid", 128'(out_valid), 128'(4'b0100));
      chk("w2_data", 128'(out_data), {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
      chk("w2_stall", 128'(stall_cnt), 128'(16'h0));
      step(1'b0, 2'd0, 32'h0, 4'b0100);
      chk("w2_release", 128'(out_valid), 128'(4'b0000));
      step(1'b0, 2'd0, 32'h0, 4'b1000);  // ack to an empty slot is ignored
      chk("ack_empty", 128'(out_valid), 128'(4'b0000));

      // Backpressure on slot 1
      step(1'b1, 2'd1, 32'h99, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11; out_ack = 4'b0000;
         #1 chk("bp_ready", 128'(in_ready), 128'(1'b0));
         @(posedge clk); #1;
      end
      chk("bp_slot1", 128'(out_data[WIDTH +: WIDTH]), 128'(32'h99));
      chk("bp_stall", 128'(stall_cnt), 128'(16'd3));
      in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11; out_ack = 4'b0010;
      #1 chk("pass_ready", 128'(in_ready), 128'(1'b1));
      @(posedge clk); #1;
      chk("pass_slot1", 128'(out_data[WIDTH +: WIDTH]), 128'(32'h11));
      chk("pass_valid", 128'(out_valid), 128'(4'b0010));
      chk("pass_stall", 128'(stall_cnt), 128'(16'd3));
      step(1'b0, 2'd0, 32'h0, 4'b0010);

      // Rotate through all four slots, then release all at once
      for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 32'hA0 + 32'(i), 4'b0000);
      chk("rot_valid", 128'(out_valid), 128'(4'b1111));
      chk("rot_data", 128'(out_data), {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      chk("rot_stall", 128'(stall_cnt), 128'(16'd3));
      step(1'b0, 2'd0, 32'h0, 4'b1111);
      chk("rot_release", 128'(out_valid), 128'(4'b0000));

      // Same-cycle refill of slot 0 with an ack to empty slot 3
      step(1'b1, 2'd0, 32'h77, 4'b0000);
      step(1'b1, 2'd0, 32'h55, 4'b1001);
      chk("refill_valid", 128'(out_valid), 128'(4'b0001));
      chk("refill_data", 128'(out_data[0 +: WIDTH]), 128'(32'h55));
      chk("refill_stall", 128'(stall_cnt), 128'(16'd3));

      // Saturate the stall counter
      for (int i = 0; i < 65536 + 5; i++) step(1'b1, 2'd0, 32'hBAD, 4'b0000);
      chk("sat_stall", 128'(stall_cnt), 128'(16'hFFFF));
      step(1'b1, 2'd0, 32'hBAD, 4'b0000);
      chk("sat_hold", 128'(stall_cnt), 128'(16'hFFFF));
      chk("sat_slot0", 128'(out_data[0 +: WIDTH]), 128'(32'h55));

      // Mid-operation reset discards the concurrent request and ack
      step(1'b1, 2'd2, 32'hC3, 4'b0000);
      rst = 1'b1;
      step(1'b1, 2'd1, 32'h1234, 4'b0001);
      rst = 1'b0;
      chk("rst_valid", 128'(out_valid), 128'(4'b0000));
      chk("rst_data", 128'(out_data), 128'h0);
      chk("rst_stall", 128'(stall_cnt), 128'(16'h0));
      idle();
      chk("rst_after", 128'(out_valid), 128'(4'b0000));

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
